// File: rtl/hazard_ctrl_if.sv
// Hazard controller interface.
// Pipeline-side hazard inputs and the sequencing controls sent back.
interface hazard_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic [ADDR_W-1:0] i_rs1_addr_id;
  logic [ADDR_W-1:0] i_rs2_addr_id;
  logic              i_rs1_used_id;
  logic              i_rs2_used_id;
  logic [ADDR_W-1:0] i_rd_addr_ex;
  logic              i_load_ex;
  logic              i_dmem_req;
  logic              i_dmem_ack;
  logic              i_redirect_ex;
  logic              i_cnt_clr;
  logic              o_stall_front;
  logic              o_bubble_ex;
  logic              o_stall_all;
  logic              o_flush;
  logic [CNT_W-1:0]  o_stall_cnt;

  modport master (
    output i_rs1_addr_id, i_rs2_addr_id,
    output i_rs1_used_id, i_rs2_used_id,
    output i_rd_addr_ex, i_load_ex,
    output i_dmem_req, i_dmem_ack,
    output i_redirect_ex, i_cnt_clr,
    input  o_stall_front, o_bubble_ex,
    input  o_stall_all, o_flush,
    input  o_stall_cnt
  );

  modport slave (
    input  i_rs1_addr_id, i_rs2_addr_id,
    input  i_rs1_used_id, i_rs2_used_id,
    input  i_rd_addr_ex, i_load_ex,
    input  i_dmem_req, i_dmem_ack,
    input  i_redirect_ex, i_cnt_clr,
    output o_stall_front, o_bubble_ex,
    output o_stall_all, o_flush,
    output o_stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall,
// data-memory wait freeze, redirect flush, stall-cycle counter.
module hazard_ctrl #(
  parameter int ADDR_W       = 5,
  parameter int CNT_W        = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input logic        i_clk,
  input logic        i_rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    FLUSH
  } state_t;

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FEXTRA = FW'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mem_wait;
  logic flush_pend;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic stall_front;
  logic bubble_ex;
  logic stall_all;
  logic flush;

  assign mem_wait = hz.i_dmem_req & ~hz.i_dmem_ack;

  // A flush interrupted by a memory wait keeps its remaining count.
  assign flush_pend = (state_q == FLUSH) ||
                      ((state_q == MEM_WAIT) && (fcnt_q != '0));

  assign rs1_hit = hz.i_rs1_used_id &&
                   (hz.i_rs1_addr_id == hz.i_rd_addr_ex);
  assign rs2_hit = hz.i_rs2_used_id &&
                   (hz.i_rs2_addr_id == hz.i_rd_addr_ex);
  assign load_use = hz.i_load_ex &&
                    (hz.i_rd_addr_ex != '0) &&
                    (rs1_hit || rs2_hit);

  // Next state and controls: mem wait > flush > load-use.
  always_comb begin
    state_d     = RUN;
    fcnt_d      = fcnt_q;
    stall_front = 1'b0;
    bubble_ex   = 1'b0;
    stall_all   = 1'b0;
    flush       = 1'b0;
    if (i_rst) begin
      flush  = 1'b1;
      fcnt_d = '0;
    end else if (mem_wait) begin
      stall_all = 1'b1;
      state_d   = MEM_WAIT;
    end else if (flush_pend) begin
      flush   = 1'b1;
      fcnt_d  = fcnt_q - FW'(1);
      state_d = (fcnt_q == FW'(1)) ? RUN : FLUSH;
    end else if (hz.i_redirect_ex) begin
      flush   = 1'b1;
      fcnt_d  = FEXTRA;
      state_d = (FEXTRA != '0) ? FLUSH : RUN;
    end else if (load_use) begin
      stall_front = 1'b1;
      bubble_ex   = 1'b1;
    end
  end

  // Saturating stall counter; clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (i_rst || hz.i_cnt_clr)
      cnt_d = '0;
    else if ((stall_front || stall_all) && !(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // State, flush count and stall counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.o_stall_front = stall_front;
  assign hz.o_bubble_ex   = bubble_ex;
  assign hz.o_stall_all   = stall_all;
  assign hz.o_flush       = flush;
  assign hz.o_stall_cnt   = i_rst ? '0 : cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus random
// traffic, scored against a cycle-level reference model.
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;
  localparam int FC = 2;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic          sf;
    logic          bx;
    logic          sa;
    logic          fl;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hazard_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) hz ();

  hazard_ctrl #(
    .ADDR_W(AW),
    .CNT_W(CW),
    .FLUSH_CYCLES(FC)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .hz(hz)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model state: extra flush cycles owed, stall count.
  int m_left = 0;
  int m_cnt = 0;

  initial begin
    hz.i_rs1_addr_id = '0;
    hz.i_rs2_addr_id = '0;
    hz.i_rs1_used_id = 1'b0;
    hz.i_rs2_used_id = 1'b0;
    hz.i_rd_addr_ex  = '0;
    hz.i_load_ex     = 1'b0;
    hz.i_dmem_req    = 1'b0;
    hz.i_dmem_ack    = 1'b0;
    hz.i_redirect_ex = 1'b0;
    hz.i_cnt_clr     = 1'b0;
  end

  task automatic step(
    input logic          r,
    input logic [AW-1:0] rs1,
    input logic [AW-1:0] rs2,
    input logic          u1,
    input logic          u2,
    input logic [AW-1:0] rd,
    input logic          ld,
    input logic          req,
    input logic          ack,
    input logic          redir,
    input logic          clr
  );
    exp_t e;
    bit haz;
    bit stall;
    @(posedge clk);
    #1;
    rst = r;
    hz.i_rs1_addr_id = rs1;
    hz.i_rs2_addr_id = rs2;
    hz.i_rs1_used_id = u1;
    hz.i_rs2_used_id = u2;
    hz.i_rd_addr_ex  = rd;
    hz.i_load_ex     = ld;
    hz.i_dmem_req    = req;
    hz.i_dmem_ack    = ack;
    hz.i_redirect_ex = redir;
    hz.i_cnt_clr     = clr;
    e = '0;
    haz = ld && (rd != 0) &&
          ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (r) begin
      e.fl = 1'b1;
      m_left = 0;
      m_cnt = 0;
    end else begin
      e.cnt = CW'(m_cnt);
      if (req && !ack) e.sa = 1'b1;
      else if (m_left > 0) begin
        e.fl = 1'b1;
        m_left = m_left - 1;
      end else if (redir) begin
        e.fl = 1'b1;
        m_left = FC - 1;
      end else if (haz) begin
        e.sf = 1'b1;
        e.bx = 1'b1;
      end
      stall = e.sf || e.sa;
      if (clr) m_cnt = 0;
      else if (stall && m_cnt < CMAX) m_cnt = m_cnt + 1;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd_step();
    logic r;
    logic req;
    r   = ($urandom_range(99) < 3);
    req = ($urandom_range(99) < 30);
    step(r,
         AW'($urandom_range(3)), AW'($urandom_range(3)),
         1'($urandom), 1'($urandom),
         AW'($urandom_range(3)),
         ($urandom_range(99) < 40),
         req, ($urandom_range(99) < 50),
         ($urandom_range(99) < 15),
         ($urandom_range(99) < 5));
  endtask

  // Monitor: pop one expectation per cycle and compare.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      a.sf  = hz.o_stall_front;
      a.bx  = hz.o_bubble_ex;
      a.sa  = hz.o_stall_all;
      a.fl  = hz.o_flush;
      a.cnt = hz.o_stall_cnt;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cyc%0d outputs: got sf=%b bx=%b sa=%b fl=%b cnt=%0d, want sf=%b bx=%b sa=%b fl=%b cnt=%0d",
                 cyc, a.sf, a.bx, a.sa, a.fl, a.cnt,
                 e.sf, e.bx, e.sa, e.fl, e.cnt);
      end
    end
  end

  initial begin
    int w;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // load-use on rs1 and rs2, then a load into x0
    step(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
    idle(1);
    step(0, 1, 7, 0, 1, 7, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    step(0, 5, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    idle(1);
    // memory wait of 3 cycles, ack, and an ack without req
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // redirect, second pulse in the flush cycle
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    // redirect together with load-use
    step(0, 3, 0, 1, 0, 3, 1, 0, 0, 1, 0);
    step(0, 3, 0, 1, 0, 3, 1, 0, 0, 0, 0);
    idle(1);
    // redirect during memory wait, acted on at ack
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    idle(2);
    // memory wait in the middle of a flush
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    idle(1);
    // saturate the counter, then clear while stalled
    for (int i = 0; i < 20; i++)
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    idle(1);
    // reset during flush and during memory wait
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 3000; i++)
      rnd_step();
    w = 0;
    while (q.size() > 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    #1;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
